// File: rtl/firo_entropy_pkg.sv
// Shared definitions for the FIRO entropy source: FSM states, word width and
// the default ring feedback polynomial.
package firo_entropy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_STALL
    } state_e;

    localparam int unsigned WORD_W       = 32;
    localparam logic [9:0]  POLY_DEFAULT = 10'b11_1111_1111;

endpackage

// File: rtl/firo_osc.sv
// One 10-stage Fibonacci ring oscillator with its parity captured every clk
// into a sample flop; the ring itself ignores enable and free-runs.
module firo_osc
    import firo_entropy_pkg::*;
#(
    parameter logic [9:0] POLY = POLY_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic parity
);

    logic [9:0] ring;
    logic       parity_q;
    logic       parity_d;

`ifdef FIRO_ICE40
    // Physical ring: kept LUT inverters, stage 0 fed by the POLY-tapped XOR.
    logic fb;
    assign fb = ^(ring & POLY);

    for (genvar gs = 0; gs < 10; gs++) begin : g_stage
        logic stage_in;
        if (gs == 0) begin : g_head
            assign stage_in = fb;
        end else begin : g_tail
            assign stage_in = ring[gs-1];
        end
        (* keep *) SB_LUT4 #(.LUT_INIT(16'h5555)) u_inv (
            .O  (ring[gs]),
            .I0 (stage_in),
            .I1 (1'b0),
            .I2 (1'b0),
            .I3 (1'b0)
        );
    end
`else
    // Behavioural stand-in: one inverter delay per clk, same feedback taps.
    logic [9:0] ring_q;
    logic [9:0] ring_d;

    always_comb begin
        ring_d = {~ring_q[8:0], ~(^(ring_q & POLY))};
    end

    always_ff @(posedge clk) begin
        if (reset) ring_q <= 10'b01_0101_0101;
        else       ring_q <= ring_d;
    end

    assign ring = ring_q;
`endif

    always_comb begin
        parity_d = ^ring;
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end

    assign parity = parity_q;

endmodule

// File: rtl/firo_entropy.sv
// FIRO entropy collector: XOR-mixes NUM_OSC ring oscillators, packs one bit per
// SAMPLE_CYCLES into 32-bit words and guards the stream with a repetition-count test.
module firo_entropy
    import firo_entropy_pkg::*;
#(
    parameter int unsigned           NUM_OSC       = 4,
    parameter logic [NUM_OSC*10-1:0] POLYS         = {NUM_OSC{POLY_DEFAULT}},
    parameter int unsigned           SAMPLE_CYCLES = 16,
    parameter int unsigned           RCT_CUTOFF    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [WORD_W-1:0] entropy_data,
    output logic              entropy_valid,
    input  logic              entropy_ack,
    output logic              health_fail
);

    localparam logic [15:0] SAMP_LAST = 16'(SAMPLE_CYCLES - 1);
    localparam logic [7:0]  RUN_CUT   = 8'(RCT_CUTOFF);

    logic [NUM_OSC-1:0] osc_bits;

    for (genvar gi = 0; gi < NUM_OSC; gi++) begin : g_osc
        firo_osc #(.POLY(POLYS[10*gi +: 10])) u_osc (
            .clk    (clk),
            .reset  (reset),
            .parity (osc_bits[gi])
        );
    end

    state_e            state_q, state_d;
    logic              mix_q, mix_d;
    logic [15:0]       samp_cnt_q, samp_cnt_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [7:0]        run_q, run_d;
    logic              prev_q, prev_d;
    logic              valid_q, valid_d;
    logic              fail_q, fail_d;
    logic              counting;
    logic              xfer;

    always_comb begin
        state_d    = state_q;
        mix_d      = ^osc_bits;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        run_d      = run_q;
        prev_d     = prev_q;
        valid_d    = valid_q;
        fail_d     = fail_q;
        counting   = 1'b0;
        xfer       = valid_q && entropy_ack;

        if (!enable) begin
            state_d    = ST_IDLE;
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            data_d     = '0;
            run_d      = '0;
            prev_d     = 1'b0;
            valid_d    = 1'b0;
        end else begin
            // The IDLE cycle that sees enable already counts as sample 0.
            case (state_q)
                ST_IDLE: begin
                    if (!fail_q) begin
                        state_d  = ST_COLLECT;
                        counting = 1'b1;
                    end
                end
                ST_COLLECT: counting = 1'b1;
                ST_STALL: begin
                    if (entropy_ack) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_COLLECT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (counting) begin
                if (xfer) valid_d = 1'b0;
                if (samp_cnt_q != SAMP_LAST) begin
                    samp_cnt_d = samp_cnt_q + 16'd1;
                end else begin
                    samp_cnt_d = '0;
                    shift_d    = {shift_q[WORD_W-2:0], mix_q};
                    bit_cnt_d  = bit_cnt_q + 5'd1;
                    prev_d     = mix_q;
                    run_d      = (run_q != '0 && mix_q == prev_q) ? run_q + 8'd1 : 8'd1;
                    if (run_d == RUN_CUT) begin
                        // Failure wins over a word completing on the same bit.
                        fail_d     = 1'b1;
                        valid_d    = 1'b0;
                        data_d     = '0;
                        state_d    = ST_IDLE;
                        samp_cnt_d = '0;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        run_d      = '0;
                        prev_d     = 1'b0;
                    end else if (bit_cnt_q == 5'd31) begin
                        if (!valid_q || entropy_ack) begin
                            data_d  = shift_d;
                            valid_d = 1'b1;
                        end else begin
                            state_d = ST_STALL;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mix_q      <= 1'b0;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            run_q      <= '0;
            prev_q     <= 1'b0;
            valid_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mix_q      <= mix_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            run_q      <= run_d;
            prev_q     <= prev_d;
            valid_q    <= valid_d;
            fail_q     <= fail_d;
        end
    end

    assign entropy_data  = data_q;
    assign entropy_valid = valid_q;
    assign health_fail   = fail_q;

endmodule

// File: tb/tb_firo_entropy.sv
// Bench for firo_entropy: oscillator outputs are forced from the bench, and a
// queue-based model of the collection rules is checked on every cycle.
module tb_firo_entropy;

    localparam int SC  = 4;
    localparam int CUT = 32;
    localparam logic [31:0] W1 = 32'hC3A5_1E69;
    localparam logic [31:0] W2 = 32'h96F0_0F35;
    localparam logic [31:0] W3 = 32'h3C5A_A5C3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        entropy_ack = 1'b0;
    logic [31:0] entropy_data;
    logic        entropy_valid;
    logic        health_fail;
    logic [3:0]  osc_drv = 4'h0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    firo_entropy #(
        .NUM_OSC       (4),
        .POLYS         ({10'h3FF, 10'h2B5, 10'h1CF, 10'h3A9}),
        .SAMPLE_CYCLES (SC),
        .RCT_CUTOFF    (CUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .entropy_data  (entropy_data),
        .entropy_valid (entropy_valid),
        .entropy_ack   (entropy_ack),
        .health_fail   (health_fail)
    );

    always #5 clk = ~clk;

    // Reference model: the mixed bit is the parity of the oscillator outputs
    // one edge earlier; collected bits queue up until 32 form a word.
    bit          m_mix = 1'b0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_hf = 1'b0;
    bit          m_stall = 1'b0;
    int          m_pos = 0;
    int          m_run = 0;
    bit          m_last = 1'b0;
    bit          m_bits[$];

    function automatic logic [31:0] pack_bits();
        logic [31:0] w;
        w = '0;
        foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
        return w;
    endfunction

    task automatic model_step();
        bit b;
        bit v0;
        b = m_mix;
        m_mix = reset ? 1'b0 : ^osc_drv;
        if (reset) begin
            m_valid = 0; m_data = '0; m_hf = 0; m_stall = 0;
            m_pos = 0; m_run = 0; m_bits.delete();
        end else if (!enable) begin
            m_valid = 0; m_data = '0; m_stall = 0;
            m_pos = 0; m_run = 0; m_bits.delete();
        end else if (m_hf) begin
            m_valid = 0;
        end else if (m_stall) begin
            if (entropy_ack) begin
                m_data = pack_bits(); m_valid = 1; m_stall = 0; m_bits.delete();
            end
        end else begin
            v0 = m_valid;
            if (v0 && entropy_ack) m_valid = 0;
            if (m_pos == SC - 1) begin
                m_pos = 0;
                m_run = (m_run != 0 && b == m_last) ? m_run + 1 : 1;
                m_last = b;
                m_bits.push_back(b);
                if (m_run == CUT) begin
                    m_hf = 1; m_valid = 0; m_data = '0; m_run = 0; m_bits.delete();
                end else if (m_bits.size() == 32) begin
                    if (!v0 || entropy_ack) begin
                        m_data = pack_bits(); m_valid = 1; m_bits.delete();
                    end else begin
                        m_stall = 1;
                    end
                end
            end else begin
                m_pos++;
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(entropy_valid), 32'(m_valid));
            chk("data", entropy_data, m_data);
            chk("health_fail", 32'(health_fail), 32'(m_hf));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Random oscillator vector whose XOR equals p.
    task automatic set_par(input bit p);
        logic [3:0] v;
        v = 4'($urandom);
        v[0] = v[0] ^ (^v) ^ p;
        osc_drv = v;
        force dut.osc_bits = osc_drv;
    endtask

    function automatic bit pat_bit(input int k);
        logic [31:0] w;
        if (k < 32)      begin w = W1; return w[31-k]; end
        else if (k < 64) begin w = W2; return w[63-k]; end
        else if (k < 96) begin w = W3; return w[95-k]; end
        return bit'($urandom);
    endfunction

    task automatic go_idle();
        enable = 0; entropy_ack = 0; reset = 0;
        tick(); tick();
    endtask

    initial begin
        set_par(1'b0);
        repeat (3) tick();
        reset = 0;
        chk_en = 1;
        tick();
        chk("reset_valid", 32'(entropy_valid), 32'd0);
        chk("reset_data", entropy_data, 32'd0);
        chk("reset_hf", 32'(health_fail), 32'd0);

        // Alternating bits starting with 1, ack held high.
        for (int rel = 0; rel < 260; rel++) begin
            tick();
            enable = 1; entropy_ack = 1;
            set_par(((rel / 4) % 2) == 0);
            if (rel == 127) chk("alt_pre_valid", 32'(entropy_valid), 32'd0);
            if (rel == 128) chk("alt_valid", 32'(entropy_valid), 32'd1);
            if (rel == 128) chk("alt_data", entropy_data, 32'hAAAA_AAAA);
            if (rel == 129) chk("alt_acked", 32'(entropy_valid), 32'd0);
            if (rel == 256) chk("alt_data2", entropy_data, 32'hAAAA_AAAA);
        end
        enable = 0;
        tick();
        chk("disable_valid", 32'(entropy_valid), 32'd0);
        chk("disable_data", entropy_data, 32'd0);

        // Same-cycle ack+completion, then STALL with a single ack pulse, then reset.
        go_idle();
        for (int rel = 0; rel <= 403; rel++) begin
            tick();
            enable = 1;
            entropy_ack = (rel == 255 || rel == 400);
            reset = (rel == 402);
            set_par(pat_bit(rel / 4));
            if (rel == 128) chk("w1_data", entropy_data, W1);
            if (rel == 255) chk("w1_held", entropy_data, W1);
            if (rel == 256) chk("w2_same_cycle_valid", 32'(entropy_valid), 32'd1);
            if (rel == 256) chk("w2_same_cycle_data", entropy_data, W2);
            if (rel == 390) chk("stall_valid", 32'(entropy_valid), 32'd1);
            if (rel == 390) chk("stall_data", entropy_data, W2);
            if (rel == 401) chk("w3_data", entropy_data, W3);
            if (rel == 401) chk("w3_valid", 32'(entropy_valid), 32'd1);
            if (rel == 403) chk("midreset_valid", 32'(entropy_valid), 32'd0);
            if (rel == 403) chk("midreset_data", entropy_data, 32'd0);
        end

        // Drop enable after 20 bits, then restart with a fresh word.
        go_idle();
        for (int rel = 0; rel < 86; rel++) begin
            tick();
            enable = (rel < 80);
            set_par(pat_bit(rel / 4));
            if (rel == 81) chk("drop_valid", 32'(entropy_valid), 32'd0);
        end
        for (int rel = 0; rel < 131; rel++) begin
            tick();
            enable = 1;
            set_par(pat_bit(32 + rel / 4));
            if (rel == 127) chk("reen_pre_valid", 32'(entropy_valid), 32'd0);
            if (rel == 128) chk("reen_valid", 32'(entropy_valid), 32'd1);
            if (rel == 128) chk("reen_data", entropy_data, W2);
        end

        // Stuck-at-1 mixed bit trips the repetition test.
        go_idle();
        for (int rel = 0; rel < 140; rel++) begin
            tick();
            enable = 1; entropy_ack = 1;
            set_par(1'b1);
            if (rel == 127) chk("rct_pre_hf", 32'(health_fail), 32'd0);
            if (rel == 128) chk("rct_hf", 32'(health_fail), 32'd1);
            if (rel == 128) chk("rct_valid", 32'(entropy_valid), 32'd0);
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            enable = ((i / 10) % 2) == 0;
            entropy_ack = 1'($urandom);
            set_par(1'($urandom));
        end
        chk("rct_sticky_hf", 32'(health_fail), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        tick();
        chk("rct_reset_hf", 32'(health_fail), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 12000; i++) begin
            tick();
            reset = ($urandom_range(0, 1999) == 0);
            if (enable) enable = ($urandom_range(0, 399) != 0);
            else        enable = ($urandom_range(0, 3) == 0);
            if (i >= 3000 && i < 6000) entropy_ack = ($urandom_range(0, 199) == 0);
            else                       entropy_ack = 1'($urandom);
            if (i >= 9000) set_par($urandom_range(0, 99) < 96);
            else           set_par(1'($urandom));
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/firo_entropy.md
FIRO_ENTROPY -- requirements
Module: firo_entropy

Interface
REQ-001 Parameter NUM_OSC, default 4, number of independent Fibonacci ring oscillators, legal range 1..16.
REQ-002 Parameter POLYS, default {NUM_OSC{10'b1111111111}}, NUM_OSC*10-bit packed feedback polynomials; channel i uses POLYS[10*i+9:10*i].
REQ-003 Parameter SAMPLE_CYCLES, default 16, clock cycles per collected bit, legal range 2..65535.
REQ-004 Parameter RCT_CUTOFF, default 32, repetition-count health-test cutoff, legal range 2..255.
REQ-005 Port clk, input, 1, single clock for all sequential logic.
REQ-006 Port reset, input, 1; one clock; reset is synchronous and active-high.
REQ-007 Port enable, input, 1, collection enable; low means idle and discard.
REQ-008 Port entropy_data, output, 32, collected entropy word.
REQ-009 Port entropy_valid, output, 1, entropy_data holds an unconsumed word.
REQ-010 Port entropy_ack, input, 1, consumer accepts the word when entropy_valid is high.
REQ-011 Port health_fail, output, 1, sticky repetition-count failure flag.

Function
REQ-012 Each oscillator SHALL free-run independently of enable; its 10-stage parity SHALL be registered every clk into a per-channel sample flop.
REQ-013 The mixed bit SHALL be the XOR of all per-channel sample flops, registered once more; the total latency from oscillator to mixed bit is 2 cycles.
REQ-014 FSM states: IDLE, COLLECT, STALL; reset and enable low force IDLE.
REQ-015 IDLE -> COLLECT on the first cycle enable is high and health_fail is 0; that cycle is cycle 0, and the sample and bit counters start at 0.
REQ-016 In COLLECT, the sample counter SHALL count 0..SAMPLE_CYCLES-1 and wrap; at the terminal count, the mixed bit is shifted into the LSB of a 32-bit shift register (shift left) and the bit counter increments.
REQ-017 On the 32nd shifted bit: if entropy_valid is 0, or entropy_ack is high that cycle, the word SHALL be loaded into entropy_data with entropy_valid=1 the next cycle; otherwise the FSM enters STALL.
REQ-018 The first entropy_valid after enable SHALL assert at cycle 32*SAMPLE_CYCLES.
REQ-019 In STALL, the counters and the shift register SHALL hold; on entropy_ack the full word transfers to entropy_data in the same edge, entropy_valid stays 1, and the FSM returns to COLLECT.
REQ-020 Handshake: a transfer occurs when entropy_valid and entropy_ack are both high at a clk edge; entropy_valid then drops unless REQ-017/REQ-019 load a new word on that same edge.
REQ-021 entropy_ack while entropy_valid=0 SHALL be ignored.
REQ-022 The repetition-count test SHALL run on every shifted bit in COLLECT: the run counter resets to 1 when the bit differs from the previous bit, and increments otherwise.
REQ-023 When the run counter reaches RCT_CUTOFF, health_fail SHALL be set next cycle, entropy_valid cleared, entropy_data zeroed, and the FSM forced to IDLE.
REQ-024 A word completing in the same cycle as the failure SHALL be discarded.
REQ-025 health_fail SHALL be cleared only by reset; while it is set, IDLE is not left.
REQ-026 enable going low in any state SHALL, next cycle, clear entropy_valid, entropy_data, the shift register, all counters, and the run counter; the partial word is discarded.

Reset
REQ-027 On reset: entropy_data=0, entropy_valid=0, health_fail=0, FSM=IDLE, all counters and the shift register at 0; the sample and mix flops SHALL also be cleared.
REQ-028 Reset mid-word or in STALL SHALL behave as REQ-027, with no partial-word output.

Structure
REQ-029 A shared package SHALL hold the FSM state encodings, the word width constant (32), and the POLY default constant.
REQ-030 Sub-module firo_osc (parameter POLY, output 1-bit registered parity) SHALL be instantiated NUM_OSC times, using kept SB_LUT4 inverters and a POLY-selected XOR feedback.
REQ-031 firo_osc SHALL provide a behavioural simulation model so that benches can force its output.

Verification
REQ-032 Reset asserted mid-operation -> all outputs 0 on the next cycle.
REQ-033 SAMPLE_CYCLES=4, mixed bit forced to alternate starting with 1, ack held high -> entropy_valid rises at cycle 128 with entropy_data=0xAAAAAAAA.
REQ-034 No ack through two words -> STALL with entropy_data=word1; ack pulsed -> entropy_data=word2 next cycle, entropy_valid held 1.
REQ-035 Mixed bit forced to 1 for 32 samples, RCT_CUTOFF=32 -> health_fail=1, entropy_valid never asserts, and enable toggling does not restart collection until reset.
REQ-036 enable dropped after 20 bits, then raised again -> entropy_valid stays 0 until 32*SAMPLE_CYCLES cycles after re-enable.
REQ-037 Ack and word completion in the same cycle -> the new word is loaded and entropy_valid stays 1.
